particle_fetcher: RTL and testbench

Sequencer directly upstream of the grid interpolator. On a start pulse it streams N particle positions out of particle memory, one read per cycle, and presents each one to the interpolator as valid/pos/user. It then counts the interpolator's returned results and pulses done once every issued particle has come back. It owns no arithmetic beyond counters and optional bounds checks.

---
 rtl/defs.sv | 30 +++
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/particle_fetcher.sv | 147 ++++++++++++++
 tb/tb_particle_fetcher.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/defs.sv
// Shared types for the particle fetch path: fixed-point positions, grid extents, fetch FSM states.
package defs;

  localparam int unsigned PFRAC  = 8;
  localparam int unsigned PWHOLE = 8;
  localparam int unsigned GRID_X = 64;
  localparam int unsigned GRID_Y = 64;

  typedef struct packed {
    logic [PWHOLE-1:0] whole;
    logic [PFRAC-1:0]  frac;
  } pcoord_t;

  typedef struct packed {
    pcoord_t x;
    pcoord_t y;
  } posvec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // True when the interpolator's whole+1 neighbour would fall outside the grid
  function automatic logic pos_out_of_range(input posvec_t p);
    return (p.x.whole > PWHOLE'(GRID_X - 2)) || (p.y.whole > PWHOLE'(GRID_Y - 2));
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// DEPTH-deep {valid, index} shift register that tracks outstanding memory reads.
module rd_tag_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IW    = 14
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [IW-1:0] in_index,
  output logic          out_valid,
  output logic [IW-1:0] out_index,
  output logic          empty_c
);

  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][IW-1:0] idx;

  // Shift one stage per cycle; clear wipes every in-flight tag
  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      idx <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_index;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_index = idx[DEPTH-1];
  assign empty_c   = ~|vld;

endmodule

// File: rtl/particle_fetcher.sv
// Streams N particle positions from memory to the grid interpolator and counts results back.
// Optional feature macro: PARTICLE_BOUNDS_CHECK_EN drops particles whose stencil leaves the grid.
module particle_fetcher
  import defs::*;
#(
  parameter int unsigned NPART_WIDTH = 14,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NPART_WIDTH:0]   num_particles,
  output logic                   busy,
  output logic                   done,
  output logic                   prt_rd_en,
  output logic [NPART_WIDTH-1:0] prt_raddr,
  input  posvec_t                prt_data,
  output logic                   valid_out,
  output posvec_t                pos_out,
  output logic [NPART_WIDTH-1:0] user_out,
  input  logic                   result_valid,
  output logic [NPART_WIDTH:0]   skipped_count
);

  localparam int unsigned NW = NPART_WIDTH + 1;

  fetch_state_t           state;
  logic [NW-1:0]          n_reg;
  logic [NW-1:0]          returned;
  logic [NW-1:0]          ret_next_c;
  logic [NW-1:0]          target_c;
  logic [NW-1:0]          skipped;
  logic                   tail_v;
  logic [NPART_WIDTH-1:0] tail_idx;
  logic                   pipe_empty_c;
  logic                   launch_c;
  logic                   last_rd_c;
  logic                   drop_c;

  rd_tag_pipe #(
    .DEPTH (RD_LAT),
    .IW    (NPART_WIDTH)
  ) u_tag_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (prt_rd_en),
    .in_index  (prt_raddr),
    .out_valid (tail_v),
    .out_index (tail_idx),
    .empty_c   (pipe_empty_c)
  );

  // Pass control and counter arithmetic
  assign launch_c   = (state == IDLE) && start && (num_particles != '0);
  assign last_rd_c  = ({1'b0, prt_raddr} == (n_reg - NW'(1)));
  assign ret_next_c = returned + NW'(result_valid && (returned < n_reg));
  assign target_c   = n_reg - skipped;

`ifdef PARTICLE_BOUNDS_CHECK_EN
  assign drop_c = pos_out_of_range(prt_data);

  // Count particles rejected at the read tail; cleared when a new pass launches
  always_ff @(posedge clk) begin
    if (rst) begin
      skipped <= '0;
    end else if (launch_c) begin
      skipped <= '0;
    end else if (tail_v && drop_c) begin
      skipped <= skipped + NW'(1);
    end
  end
`else
  assign drop_c  = 1'b0;
  assign skipped = '0;
`endif

  assign skipped_count = skipped;

  // Register returning read data onto the interpolator interface
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      pos_out   <= '0;
      user_out  <= '0;
    end else begin
      valid_out <= tail_v && !drop_c;
      if (tail_v && !drop_c) begin
        pos_out  <= prt_data;
        user_out <= tail_idx;
      end
    end
  end

  // Fetch FSM: issue reads back-to-back, then wait for pipeline drain and all results
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      prt_rd_en <= 1'b0;
      prt_raddr <= '0;
      n_reg     <= '0;
      returned  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_particles != '0) begin
              n_reg     <= num_particles;
              returned  <= '0;
              prt_raddr <= '0;
              prt_rd_en <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          returned <= ret_next_c;
          if (last_rd_c) begin
            prt_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            prt_raddr <= prt_raddr + NPART_WIDTH'(1);
          end
        end
        DRAIN: begin
          returned <= ret_next_c;
          if (pipe_empty_c && (ret_next_c >= target_c)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          prt_rd_en <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_particle_fetcher.sv
// Directed bench for particle_fetcher with a latency-matched memory and fixed-delay result model.
module tb_particle_fetcher;
  import defs::*;

  localparam int unsigned NPW    = 14;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DLY    = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NPW:0]     num_particles;
  logic             busy;
  logic             done;
  logic             prt_rd_en;
  logic [NPW-1:0]   prt_raddr;
  posvec_t          prt_data;
  logic             valid_out;
  posvec_t          pos_out;
  logic [NPW-1:0]   user_out;
  logic             result_valid;
  logic [NPW:0]     skipped_count;

  posvec_t          mem [16];
  posvec_t          dl  [RD_LAT];
  logic [DLY-1:0]   rsh = '0;
  logic             spur;

  int ncmp = 0;
  int nerr = 0;

  particle_fetcher #(
    .NPART_WIDTH (NPW),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_particles (num_particles),
    .busy          (busy),
    .done          (done),
    .prt_rd_en     (prt_rd_en),
    .prt_raddr     (prt_raddr),
    .prt_data      (prt_data),
    .valid_out     (valid_out),
    .pos_out       (pos_out),
    .user_out      (user_out),
    .result_valid  (result_valid),
    .skipped_count (skipped_count)
  );

  always #5 clk = ~clk;

  // Memory with RD_LAT-cycle read latency, and interpolator answering DLY cycles after valid_out
  always @(posedge clk) begin
    dl[0] <= mem[prt_raddr[3:0]];
    for (int i = 1; i < int'(RD_LAT); i++) dl[i] <= dl[i-1];
    rsh <= {rsh[DLY-2:0], valid_out};
  end

  assign prt_data     = dl[RD_LAT-1];
  assign result_valid = rsh[DLY-1] | spur;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pass: pulse start, then check every cycle against hand-derived timing
  task automatic run_pass(input int n, input int done_s, input int drop_k, input int restart_s);
    num_particles = (NPW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 1; s <= done_s + 3; s++) begin
      int  k;
      logic vexp;
      k    = s - 2 - int'(RD_LAT);
      vexp = (k >= 0) && (k < n) && (k != drop_k);
      chk($sformatf("rd_en n=%0d s=%0d", n, s), 32'(prt_rd_en), 32'(s <= n));
      if (s <= n) chk($sformatf("raddr n=%0d s=%0d", n, s), 32'(prt_raddr), 32'(s - 1));
      chk($sformatf("valid n=%0d s=%0d", n, s), 32'(valid_out), 32'(vexp));
      if (vexp) begin
        chk($sformatf("user n=%0d s=%0d", n, s), 32'(user_out), 32'(k));
        chk($sformatf("pos n=%0d s=%0d", n, s), 32'(pos_out), 32'(mem[k]));
      end
      chk($sformatf("done n=%0d s=%0d", n, s), 32'(done), 32'(s == done_s));
      chk($sformatf("busy n=%0d s=%0d", n, s), 32'(busy), 32'(s < done_s));
      start = (s == restart_s);
      if (s == restart_s) num_particles = (NPW+1)'(3);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i].x.whole = PWHOLE'(i * 3 + 1);
      mem[i].x.frac  = PFRAC'(i * 17 + 3);
      mem[i].y.whole = PWHOLE'(i + 5);
      mem[i].y.frac  = PFRAC'(8'h40 + i);
    end
    mem[1].x.whole = PWHOLE'(63);
    for (int i = 0; i < int'(RD_LAT); i++) dl[i] = '0;

    rst = 1'b1;
    start = 1'b0;
    num_particles = '0;
    spur = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst rd_en", 32'(prt_rd_en), 32'(0));
    chk("rst valid", 32'(valid_out), 32'(0));
    chk("rst raddr", 32'(prt_raddr), 32'(0));
    chk("rst pos", 32'(pos_out), 32'(0));
    chk("rst user", 32'(user_out), 32'(0));
    chk("rst skipped", 32'(skipped_count), 32'(0));
    rst = 1'b0;
    tick();

    // N=4: reads 1..4, valid_out 4..7, results 16..19, done 20
    run_pass(4, 20, -1, -1);
    repeat (4) tick();

    // N=0: done next cycle, no reads, never busy
    num_particles = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("n0 done", 32'(done), 32'(1));
    chk("n0 busy", 32'(busy), 32'(0));
    chk("n0 rd_en", 32'(prt_rd_en), 32'(0));
    for (int s = 2; s <= 5; s++) begin
      tick();
      chk($sformatf("n0 done s=%0d", s), 32'(done), 32'(0));
      chk($sformatf("n0 rd_en s=%0d", s), 32'(prt_rd_en), 32'(0));
      chk($sformatf("n0 busy s=%0d", s), 32'(busy), 32'(0));
    end

    // N=8 with a second start while busy: ignored, 8 reads, single done at 24
    run_pass(8, 24, -1, 2);
    repeat (4) tick();

    // Reset after 3 reads: everything clears, in-flight reads never surface
    num_particles = (NPW+1)'(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid rd_en s3", 32'(prt_rd_en), 32'(1));
    chk("mid raddr s3", 32'(prt_raddr), 32'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid busy", 32'(busy), 32'(0));
    chk("mid done", 32'(done), 32'(0));
    chk("mid rd_en", 32'(prt_rd_en), 32'(0));
    chk("mid valid", 32'(valid_out), 32'(0));
    chk("mid raddr", 32'(prt_raddr), 32'(0));
    chk("mid pos", 32'(pos_out), 32'(0));
    chk("mid user", 32'(user_out), 32'(0));
    for (int s = 0; s < 20; s++) begin
      tick();
      chk($sformatf("post-rst valid c=%0d", s), 32'(valid_out), 32'(0));
      chk($sformatf("post-rst done c=%0d", s), 32'(done), 32'(0));
      chk($sformatf("post-rst busy c=%0d", s), 32'(busy), 32'(0));
    end

    // N=3 with particle 1 at x.whole=63 (out of range when the bounds check is built in)
`ifdef PARTICLE_BOUNDS_CHECK_EN
    run_pass(3, 19, 1, -1);
    chk("bounds skipped", 32'(skipped_count), 32'(1));
`else
    run_pass(3, 19, -1, -1);
    chk("bounds skipped", 32'(skipped_count), 32'(0));
`endif
    repeat (4) tick();

    // Spurious results in IDLE are ignored, then N=2 completes on its own two results
    spur = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("spur done c=%0d", s), 32'(done), 32'(0));
      chk($sformatf("spur busy c=%0d", s), 32'(busy), 32'(0));
    end
    spur = 1'b0;
    run_pass(2, 18, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
